// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready handshake plus imem write port.
// master = loader side (drives rx_ready, imem_*); slave = host/memory side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 6
) ();
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a count-prefixed LE byte stream into 32-bit words,
// writes them into imem and holds the core in reset until the image is good.
// Ports: clk, reset (sync, active high), start pulse, bus (imem_loader_if
// master: rx_valid/rx_data/rx_ready, imem_we/imem_addr/imem_wdata),
// core_reset, busy, done, error.
// Option: define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);
  localparam int          IW  = ADDR_WIDTH + 1;
  localparam int unsigned CAP = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE,
    S_CHECK, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] word_idx_q, word_idx_d;
  logic [IW-1:0] n_q, n_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   asm_q, asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    acc_q, acc_d;
`endif
  logic          xfer;
  logic          cnt_bad;

  assign bus.rx_ready = (state_q == S_COUNT)
                     || (state_q == S_DATA)
                     || (state_q == S_CHECK);
  assign xfer = bus.rx_valid && bus.rx_ready;
  // a write still pending when reset arrives is suppressed
  assign bus.imem_we    = (state_q == S_WRITE) && !reset;
  assign bus.imem_addr  = word_idx_q[ADDR_WIDTH-1:0];
  assign bus.imem_wdata = asm_q;
  assign busy  = bus.rx_ready || (state_q == S_WRITE);
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_ERR);
  assign core_reset = !done;
  assign cnt_bad = (bus.rx_data == 8'd0)
                || (32'(bus.rx_data) > CAP);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_COUNT;
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_d      = '0;
`endif
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if (cnt_bad) begin
            state_d = S_ERR;
          end else begin
            n_d     = IW'(bus.rx_data);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_d = acc_q ^ bus.rx_data;
`endif
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + IW'(1);
        if (word_idx_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          state_d = (bus.rx_data == acc_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      n_q        <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end
endmodule
